ro_measure_ctrl: RTL and testbench

//  Sequences one ring-oscillator frequency measurement per request, or runs them back to back.
//  - Enables the RO and waits for it to settle.
//  - Aligns to the free-running window timer's single-cycle win_done pulse.
//  - Counts RO rising edges over exactly one window, then latches the count.
//  - Streams a header byte plus the count, MSB first, to the UART TX through a valid/ready handshake.

---
 rtl/ro_measure_ctrl_pkg.sv | 16 +
 rtl/ro_edge_counter.sv | 55 +++++
 rtl/ro_measure_ctrl.sv | 158 +++++++++++++++
 tb/tb_ro_measure_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_measure_ctrl_pkg.sv
// Shared definitions for the ring-oscillator measurement controller:
// FSM state encoding and the default frame header byte.
package ro_measure_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_ARM     = 3'd2,
      ST_MEASURE = 3'd3,
      ST_SEND    = 3'd4
   } state_e;

   localparam logic [7:0] HDR_DEFAULT = 8'hA4;
   localparam int         BYTE_W      = 8;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronizes the raw RO output, detects rising edges and counts them into a
// saturating counter with a sticky overflow bit.
module ro_edge_counter #(
   parameter int CNT_W    = 24,
   parameter int SYNC_STG = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ro_in,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt_now,
   output logic             ovf_now
);

   logic [SYNC_STG-1:0] sync_q;
   logic                prev_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                rise;

   assign rise = sync_q[SYNC_STG-1] & ~prev_q;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (en && rise) begin
         if (&cnt_q) ovf_d = 1'b1;
         else        cnt_d = cnt_q + 1'b1;
      end
   end

   // The controller latches the next-state values so an edge in the window's
   // final cycle is still part of the result.
   assign cnt_now = cnt_d;
   assign ovf_now = ovf_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STG-2:0], ro_in};
         prev_q <= sync_q[SYNC_STG-1];
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule

// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement sequencer: settle, align to the window timer,
// count one window of RO edges, then stream header + count to the UART.
module ro_measure_ctrl
   import ro_measure_ctrl_pkg::*;
#(
   parameter int          CNT_W      = 24,
   parameter int          NBYTES     = 3,
   parameter int          SYNC_STG   = 2,
   parameter int          SETTLE_CYC = 16,
   parameter logic [7:0]  HDR        = HDR_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cont_mode,
   input  logic             abort,
   input  logic             win_done,
   input  logic             ro_in,
   output logic             ro_en,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [CNT_W-1:0] result,
   output logic             result_valid,
   output logic             overflow,
   output logic             busy
);

   localparam int IDX_W = $clog2(NBYTES + 1);
   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam int PAD_W = NBYTES * BYTE_W;

   state_e              state_q;
   logic [SET_W-1:0]    settle_q;
   logic                ro_en_q;
   logic [CNT_W-1:0]    result_q;
   logic                ovf_q;
   logic                rv_q;
   logic                tx_valid_q;
   logic [7:0]          tx_data_q;
   logic [PAD_W-1:0]    shift_q;
   logic [IDX_W-1:0]    idx_q;
   logic                abort_pend_q;

   logic [CNT_W-1:0]    cnt_now;
   logic                ovf_now;
   logic [PAD_W-1:0]    result_pad;

   assign result_pad = PAD_W'(result_q);

   ro_edge_counter #(
      .CNT_W    (CNT_W),
      .SYNC_STG (SYNC_STG)
   ) u_edge_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .ro_in   (ro_in),
      .clr     ((state_q == ST_ARM) && win_done),
      .en      (state_q == ST_MEASURE),
      .cnt_now (cnt_now),
      .ovf_now (ovf_now)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         settle_q     <= '0;
         ro_en_q      <= 1'b0;
         result_q     <= '0;
         ovf_q        <= 1'b0;
         rv_q         <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         shift_q      <= '0;
         idx_q        <= '0;
         abort_pend_q <= 1'b0;
      end else begin
         rv_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_q  <= ST_SETTLE;
                  ro_en_q  <= 1'b1;
                  settle_q <= '0;
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  ro_en_q <= 1'b0;
               end else if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
                  state_q <= ST_ARM;
               end else begin
                  settle_q <= settle_q + 1'b1;
               end
            end
            ST_ARM: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  ro_en_q <= 1'b0;
               end else if (win_done) begin
                  state_q <= ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  ro_en_q <= 1'b0;
               end else if (win_done) begin
                  result_q <= cnt_now;
                  ovf_q    <= ovf_now;
                  rv_q     <= 1'b1;
                  idx_q    <= '0;
                  state_q  <= ST_SEND;
               end
            end
            ST_SEND: begin
               // An abort here only marks the frame as the last one.
               if (abort) abort_pend_q <= 1'b1;
               if (rv_q) begin
                  tx_valid_q <= 1'b1;
                  tx_data_q  <= {HDR[7:1], ovf_q};
                  shift_q    <= result_pad;
                  idx_q      <= '0;
               end else if (tx_valid_q && tx_ready) begin
                  if (idx_q == IDX_W'(NBYTES)) begin
                     tx_valid_q   <= 1'b0;
                     abort_pend_q <= 1'b0;
                     if (cont_mode && !abort_pend_q && !abort) begin
                        state_q <= ST_ARM;
                     end else begin
                        state_q <= ST_IDLE;
                        ro_en_q <= 1'b0;
                     end
                  end else begin
                     tx_data_q <= shift_q[PAD_W-1 -: BYTE_W];
                     shift_q   <= shift_q << BYTE_W;
                     idx_q     <= idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ro_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign ro_en        = ro_en_q;
   assign tx_data      = tx_data_q;
   assign tx_valid     = tx_valid_q;
   assign result       = result_q;
   assign result_valid = rv_q;
   assign overflow     = ovf_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Directed scoreboard bench: a 24-bit instance for framing, backpressure,
// continuous mode, abort and reset, plus a 4-bit instance for saturation.
module tb_ro_measure_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, start4 = 1'b0;
   logic        cont_mode = 1'b0, abort = 1'b0;
   logic        win_done = 1'b0, ro_in = 1'b0, ro_in4 = 1'b0;
   logic        tx_ready = 1'b1;

   logic        ro_en, tx_valid, result_valid, overflow, busy;
   logic [7:0]  tx_data;
   logic [23:0] result;
   logic        ro_en4, tx_valid4, result_valid4, overflow4, busy4;
   logic [7:0]  tx_data4;
   logic [3:0]  result4;

   int          tests = 0, fails = 0;
   int          cyc = 0, win_cnt = 0;
   logic [7:0]  exp_q[$], exp4_q[$];
   logic [24:0] res_q[$];
   logic [4:0]  res4_q[$];
   int          rv_cnt = 0, rv4_cnt = 0;
   int          rv_cyc[$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;

   ro_measure_ctrl #(.CNT_W(24), .NBYTES(3), .SYNC_STG(2), .SETTLE_CYC(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cont_mode(cont_mode), .abort(abort),
      .win_done(win_done), .ro_in(ro_in), .ro_en(ro_en), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .result(result),
      .result_valid(result_valid), .overflow(overflow), .busy(busy));

   ro_measure_ctrl #(.CNT_W(4), .NBYTES(1), .SYNC_STG(2), .SETTLE_CYC(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .cont_mode(1'b0), .abort(1'b0),
      .win_done(win_done), .ro_in(ro_in4), .ro_en(ro_en4), .tx_data(tx_data4),
      .tx_valid(tx_valid4), .tx_ready(1'b1), .result(result4),
      .result_valid(result_valid4), .overflow(overflow4), .busy(busy4));

   always #5 clk = ~clk;

   // Window timer every 100 clk, RO period 10 clk (period 4 for the small instance).
   always @(posedge clk) begin
      #1;
      cyc++;
      win_cnt  = (win_cnt == 99) ? 0 : win_cnt + 1;
      win_done = (win_cnt == 99);
      ro_in    = ((cyc % 10) < 5);
      ro_in4   = ((cyc % 4) < 2);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
            end else begin
               check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
         end
         if (result_valid) begin
            rv_cnt++;
            rv_cyc.push_back(cyc);
            if (res_q.size() == 0) begin
               tests++;
               fails++;
               $error("FAIL unexpected_result: observed %0h expected none", result);
            end else begin
               check("result", {7'd0, overflow, result}, {7'd0, res_q.pop_front()});
            end
         end
         if (tx_valid4) begin
            if (exp4_q.size() == 0) begin
               tests++;
               fails++;
               $error("FAIL unexpected_byte4: observed %0h expected none", tx_data4);
            end else begin
               check("tx_byte4", {24'd0, tx_data4}, {24'd0, exp4_q.pop_front()});
            end
         end
         if (result_valid4) begin
            rv4_cnt++;
            if (res4_q.size() != 0)
               check("result4", {27'd0, overflow4, result4}, {27'd0, res4_q.pop_front()});
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic push_frame(input logic ovf, input logic [23:0] val);
      exp_q.push_back({7'h52, ovf});
      exp_q.push_back(val[23:16]);
      exp_q.push_back(val[15:8]);
      exp_q.push_back(val[7:0]);
      res_q.push_back({ovf, val});
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      while (busy && n < max) begin
         tick();
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic wait_valid(input string tag, input int max);
      int n = 0;
      while (!tx_valid && n < max) begin
         tick();
         n++;
      end
      check(tag, {31'd0, tx_valid}, 32'd1);
   endtask

   initial begin
      int base;
      int ro_low;
      int n;

      repeat (3) tick();
      check("rst_ro_en", {31'd0, ro_en}, 32'd0);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_result", {8'd0, result}, 32'd0);
      check("rst_result_valid", {31'd0, result_valid}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      // Single measurement
      base = rv_cnt;
      push_frame(1'b0, 24'd10);
      pulse_start();
      wait_idle("t1_idle", 400);
      check("t1_ro_en", {31'd0, ro_en}, 32'd0);
      check("t1_rv_cnt", rv_cnt - base, 32'd1);
      check("t1_drain", exp_q.size(), 32'd0);

      // Backpressure: hold tx_ready low 5 cycles on every byte
      tx_ready = 1'b0;
      push_frame(1'b0, 24'd10);
      pulse_start();
      for (int b = 0; b < 4; b++) begin
         wait_valid("t2_valid", 400);
         repeat (5) tick();
         tx_ready = 1'b1;
         tick();
         tx_ready = 1'b0;
      end
      tx_ready = 1'b1;
      wait_idle("t2_idle", 50);
      check("t2_drain", exp_q.size(), 32'd0);

      // Saturation on the 4-bit instance
      exp4_q.push_back(8'hA5);
      exp4_q.push_back(8'h0F);
      res4_q.push_back({1'b1, 4'hF});
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n = 0;
      while (busy4 && n < 400) begin
         tick();
         n++;
      end
      check("t3_idle", {31'd0, busy4}, 32'd0);
      check("t3_rv_cnt", rv4_cnt, 32'd1);
      check("t3_drain", exp4_q.size(), 32'd0);

      // Continuous mode: two frames, ro_en held throughout
      cont_mode = 1'b1;
      base = rv_cnt;
      ro_low = 0;
      push_frame(1'b0, 24'd10);
      push_frame(1'b0, 24'd10);
      pulse_start();
      n = 0;
      while (rv_cnt == base && n < 400) begin
         if (!ro_en) ro_low++;
         tick();
         n++;
      end
      while (!tx_valid && n < 400) begin
         if (!ro_en) ro_low++;
         tick();
         n++;
      end
      while (tx_valid && n < 400) begin
         if (!ro_en) ro_low++;
         tick();
         n++;
      end
      cont_mode = 1'b0;
      while (busy && n < 800) begin
         if (!ro_en) ro_low++;
         tick();
         n++;
      end
      check("t4_idle", {31'd0, busy}, 32'd0);
      check("t4_ro_en_held", ro_low, 32'd0);
      check("t4_rv_cnt", rv_cnt - base, 32'd2);
      if (rv_cyc.size() >= 2)
         check("t4_frame_gap", rv_cyc[rv_cyc.size()-1] - rv_cyc[rv_cyc.size()-2], 32'd200);
      check("t4_drain", exp_q.size(), 32'd0);

      // Abort in MEASURE
      base = rv_cnt;
      pulse_start();
      repeat (6) tick();
      n = 0;
      while (!win_done && n < 200) begin
         tick();
         n++;
      end
      repeat (11) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5a_busy", {31'd0, busy}, 32'd0);
      check("t5a_ro_en", {31'd0, ro_en}, 32'd0);
      repeat (150) tick();
      check("t5a_no_result", rv_cnt - base, 32'd0);
      check("t5a_result_kept", {8'd0, result}, 32'd10);

      // Abort during byte 1 with cont_mode set, plus an ignored second start
      cont_mode = 1'b1;
      base = rv_cnt;
      push_frame(1'b0, 24'd10);
      pulse_start();
      tick();
      pulse_start();
      wait_valid("t5b_valid", 400);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      wait_idle("t5b_idle", 50);
      cont_mode = 1'b0;
      check("t5b_ro_en", {31'd0, ro_en}, 32'd0);
      check("t5b_rv_cnt", rv_cnt - base, 32'd1);
      check("t5b_drain", exp_q.size(), 32'd0);

      // Reset mid-SEND, then a fresh frame
      tx_ready = 1'b0;
      push_frame(1'b0, 24'd10);
      pulse_start();
      wait_valid("t6_valid", 400);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_ro_en", {31'd0, ro_en}, 32'd0);
      check("t6_result", {8'd0, result}, 32'd0);
      check("t6_overflow", {31'd0, overflow}, 32'd0);
      exp_q.delete();
      tx_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      push_frame(1'b0, 24'd10);
      pulse_start();
      wait_idle("t6_idle", 400);
      check("t6_result_after", {8'd0, result}, 32'd10);
      check("t6_drain", exp_q.size(), 32'd0);

      check("final_results_drained", res_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
